// File: rtl/tl45_fetch_if.sv
// Instruction-fetch read bus: single-outstanding req/ack handshake between the fetch stage
// (master) and the instruction memory (slave).
interface tl45_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] data;
  logic        err;

  modport master (
    output req,
    output addr,
    input  ack,
    input  data,
    input  err
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output data,
    output err
  );
endinterface

// File: rtl/tl45_fetch.sv
// TL45 instruction fetch stage: owns the PC, issues one read at a time and fills the
// fetch->decode buffer with a word or a NOP bubble, honouring stall, flush and redirect.
module tl45_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4,
  parameter logic [31:0] ERR_INST = 32'hFFFF_FFFF
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_pipe_stall,
  input  logic               i_pipe_flush,
  input  logic [31:0]        i_new_pc,
  tl45_fetch_if.master       io_mem,
  output logic [31:0]        o_buf_pc,
  output logic [31:0]        o_buf_inst,
  output logic               o_fetch_err
);

  localparam logic [31:0] PcStep = 32'(PC_STEP);

  typedef enum logic [1:0] {
    StFetch,
    StHold,
    StDrop
  } state_e;

  state_e      r_state, w_state_d;
  logic [31:0] r_pc, w_pc_d;
  logic [31:0] r_drop_addr, w_drop_addr_d;
  logic [31:0] r_hold_pc, w_hold_pc_d;
  logic [31:0] r_hold_inst, w_hold_inst_d;
  logic        r_hold_err, w_hold_err_d;
  logic [31:0] r_buf_pc, w_buf_pc_d;
  logic [31:0] r_buf_inst, w_buf_inst_d;
  logic        r_fetch_err, w_fetch_err_d;
  logic [31:0] w_word;

  assign w_word = io_mem.err ? ERR_INST : io_mem.data;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= StFetch;
      r_pc        <= RESET_PC;
      r_drop_addr <= '0;
      r_hold_pc   <= '0;
      r_hold_inst <= '0;
      r_hold_err  <= 1'b0;
      r_buf_pc    <= '0;
      r_buf_inst  <= '0;
      r_fetch_err <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_pc        <= w_pc_d;
      r_drop_addr <= w_drop_addr_d;
      r_hold_pc   <= w_hold_pc_d;
      r_hold_inst <= w_hold_inst_d;
      r_hold_err  <= w_hold_err_d;
      r_buf_pc    <= w_buf_pc_d;
      r_buf_inst  <= w_buf_inst_d;
      r_fetch_err <= w_fetch_err_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_pc_d        = r_pc;
    w_drop_addr_d = r_drop_addr;
    w_hold_pc_d   = r_hold_pc;
    w_hold_inst_d = r_hold_inst;
    w_hold_err_d  = r_hold_err;
    w_buf_pc_d    = r_buf_pc;
    w_buf_inst_d  = r_buf_inst;
    w_fetch_err_d = 1'b0;

    unique case (r_state)
      StFetch: begin
        if (i_pipe_flush) begin
          w_pc_d       = i_new_pc;
          w_buf_pc_d   = '0;
          w_buf_inst_d = '0;
          // An unacked request cannot be withdrawn; park its address and let it complete.
          if (!io_mem.ack) begin
            w_drop_addr_d = r_pc;
            w_state_d     = StDrop;
          end
        end else if (io_mem.ack) begin
          if (i_pipe_stall) begin
            w_hold_pc_d   = r_pc;
            w_hold_inst_d = w_word;
            w_hold_err_d  = io_mem.err;
            w_state_d     = StHold;
          end else begin
            w_buf_pc_d    = r_pc;
            w_buf_inst_d  = w_word;
            w_fetch_err_d = io_mem.err;
            w_pc_d        = r_pc + PcStep;
          end
        end else if (!i_pipe_stall) begin
          w_buf_pc_d   = '0;
          w_buf_inst_d = '0;
        end
      end

      StHold: begin
        if (i_pipe_flush) begin
          w_pc_d       = i_new_pc;
          w_buf_pc_d   = '0;
          w_buf_inst_d = '0;
          w_state_d    = StFetch;
        end else if (!i_pipe_stall) begin
          w_buf_pc_d    = r_hold_pc;
          w_buf_inst_d  = r_hold_inst;
          w_fetch_err_d = r_hold_err;
          w_pc_d        = r_pc + PcStep;
          w_state_d     = StFetch;
        end
      end

      StDrop: begin
        if (i_pipe_flush) begin
          w_pc_d       = i_new_pc;
          w_buf_pc_d   = '0;
          w_buf_inst_d = '0;
        end else if (!i_pipe_stall) begin
          w_buf_pc_d   = '0;
          w_buf_inst_d = '0;
        end
        if (io_mem.ack) begin
          w_state_d = StFetch;
        end
      end

      default: w_state_d = StFetch;
    endcase
  end

  assign io_mem.req  = ((r_state == StFetch) || (r_state == StDrop)) && i_reset_n;
  assign io_mem.addr = (r_state == StDrop) ? r_drop_addr : r_pc;

  assign o_buf_pc    = r_buf_pc;
  assign o_buf_inst  = r_buf_inst;
  assign o_fetch_err = r_fetch_err;

endmodule

// File: tb/tb_tl45_fetch.sv
// Randomised scoreboard bench for tl45_fetch: expected instruction stream derived from PC
// sequencing rules, checked against every word the stage delivers into the decode buffer.
module tb_tl45_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] ERR_INST = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] new_pc = '0;
  logic [31:0] buf_pc;
  logic [31:0] buf_inst;
  logic        fetch_err;

  tl45_fetch_if mem_if ();

  tl45_fetch #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (4),
    .ERR_INST (ERR_INST)
  ) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_pipe_stall (stall),
    .i_pipe_flush (flush),
    .i_new_pc     (new_pc),
    .io_mem       (mem_if),
    .o_buf_pc     (buf_pc),
    .o_buf_inst   (buf_inst),
    .o_fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents: nonzero word per address, errors on a sparse address pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) | 32'h1;
  endfunction

  function automatic logic mem_bad(input logic [31:0] a);
    return ((a >> 2) % 7) == 3;
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] tail_pc;

  task automatic topup();
    exp_t e;
    while (exp_q.size() < 32) begin
      e.pc   = tail_pc;
      e.err  = mem_bad(tail_pc);
      e.inst = e.err ? ERR_INST : mem_word(tail_pc);
      exp_q.push_back(e);
      tail_pc = tail_pc + 32'd4;
    end
  endtask

  // Delivered program order restarts at the given target; anything in flight is lost.
  task automatic restart(input logic [31:0] p);
    exp_q.delete();
    tail_pc = p;
    topup();
  endtask

  // Memory slave: random latency, garbage data when not acking, request-stability checks.
  logic        fast_mem = 1'b0;
  int          lat = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;

  initial begin
    mem_if.ack  = 1'b0;
    mem_if.data = '0;
    mem_if.err  = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      mem_if.ack = 1'b0;
      pend = 1'b0;
      lat = 0;
    end else begin
      if (pend) begin
        check("req_held", 32'(mem_if.req), 32'd1);
        check("addr_stable", mem_if.addr, pend_addr);
      end
      if (mem_if.req && (fast_mem || lat == 0)) begin
        mem_if.ack  = 1'b1;
        mem_if.data = mem_word(mem_if.addr);
        mem_if.err  = mem_bad(mem_if.addr);
        lat = $urandom_range(0, 3);
      end else begin
        mem_if.ack  = 1'b0;
        mem_if.data = $urandom;
        mem_if.err  = 1'($urandom);
        if (mem_if.req && lat > 0) lat--;
      end
      pend      = mem_if.req && !mem_if.ack;
      pend_addr = mem_if.addr;
    end
  end

  // Monitor: classify each edge by the pipeline controls it saw and compare the buffer.
  logic [31:0] last_pc = '0;
  logic [31:0] last_inst = '0;
  logic        p_stall, p_flush, p_rst;
  int          idle = 0;
  exp_t        got;

  always @(posedge clk) begin
    p_stall = stall;
    p_flush = flush;
    p_rst   = rst_n;
    #1;
    if (p_rst && rst_n) begin
      if (p_flush) begin
        check("flush_pc", buf_pc, 32'd0);
        check("flush_inst", buf_inst, 32'd0);
        check("flush_err", 32'(fetch_err), 32'd0);
      end else if (p_stall) begin
        check("stall_pc", buf_pc, last_pc);
        check("stall_inst", buf_inst, last_inst);
        check("stall_err", 32'(fetch_err), 32'd0);
      end else if (buf_inst != 32'd0) begin
        idle = 0;
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          got = exp_q.pop_front();
          check("deliver_pc", buf_pc, got.pc);
          check("deliver_inst", buf_inst, got.inst);
          check("deliver_err", 32'(fetch_err), 32'(got.err));
        end
      end else begin
        check("bubble_pc", buf_pc, 32'd0);
        check("bubble_err", 32'(fetch_err), 32'd0);
        idle++;
        if (idle > 40) begin
          check("progress_timeout", 32'(idle), 32'd40);
          idle = 0;
        end
      end
    end else begin
      idle = 0;
    end
    last_pc   = buf_pc;
    last_inst = buf_inst;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_buf_pc"}, buf_pc, 32'd0);
    check({tag, "_buf_inst"}, buf_inst, 32'd0);
    check({tag, "_fetch_err"}, 32'(fetch_err), 32'd0);
    check({tag, "_mem_req"}, 32'(mem_if.req), 32'd0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    restart(RESET_PC);
  endtask

  task automatic mid_reset(input string tag);
    @(negedge clk);
    stall = 1'b0;
    flush = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    repeat (2) @(posedge clk);
    release_reset();
  endtask

  initial begin
    restart(RESET_PC);
    #1;
    check_reset_outputs("reset");
    check("reset_addr", mem_if.addr, RESET_PC);
    repeat (3) @(posedge clk);
    release_reset();

    // Zero-wait memory, no stall: three edges deliver PCs 0, 4, 8.
    fast_mem = 1'b1;
    repeat (4) @(negedge clk);
    check("first_stream_pc", buf_pc, RESET_PC + 32'd8);
    check("first_stream_inst", buf_inst, mem_word(RESET_PC + 32'd8));
    fast_mem = 1'b0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc == 1500) mid_reset("reset_mid1");
      if (cyc == 3000) mid_reset("reset_mid2");
      @(negedge clk);
      topup();
      stall = ($urandom_range(0, 99) < 30);
      flush = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 9) == 0) new_pc = 32'hFFFF_FFF8;
      else new_pc = 32'($urandom_range(0, 255)) << 2;
      if (flush) restart(new_pc);
    end

    @(negedge clk);
    stall = 1'b0;
    flush = 1'b0;
    repeat (20) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
